// File: rtl/slice_config_loader_pkg.sv
// Shared types and sizing helpers for the CLB slice config loaders.
// Frame geometry is derived from the slice LUT input base and LUT count.
package clb_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT,
    DONE
  } cfg_state_t;

  function automatic int frame_bits(
    input int s_xx_base,
    input int num_luts
  );
    return num_luts * 2 * ((1 << s_xx_base) + 1) + 1;
  endfunction

  function automatic int cnt_w(
    input int s_xx_base,
    input int num_luts
  );
    return $clog2(frame_bits(s_xx_base, num_luts) + 1);
  endfunction

endpackage

// File: rtl/slice_config_loader_cfg_shift_reg.sv
// Left-shifting serial-in register with shift enable and sync clear.
// Shared by the slice and routing configuration loaders.
module cfg_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             shift_en_i,
  input  logic             bit_i,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (clr_i) begin
      data_d = '0;
    end else if (shift_en_i) begin
      data_d = {data_q[WIDTH-2:0], bit_i};
    end
  end

  always_ff @(posedge clk_i) begin
    data_q <= data_d;
  end

  assign data_o = data_q;

endmodule

// File: rtl/slice_config_loader.sv
// Serial frame loader feeding one logic slice's LUT and carry config.
// The whole frame is presented at once with a one-cycle config_en strobe.
module slice_config_loader
  import clb_cfg_pkg::*;
#(
  parameter int S_XX_BASE = 4,
  parameter int CFG_SIZE = 2**S_XX_BASE + 1,
  parameter int NUM_LUTS = 4,
  localparam int FRAME_BITS = frame_bits(S_XX_BASE, NUM_LUTS),
  localparam int CNT_W = cnt_w(S_XX_BASE, NUM_LUTS)
) (
  input  logic config_clk,
  input  logic config_rst,
  input  logic cfg_start,
  input  logic cfg_bit,
  input  logic cfg_valid,
  output logic cfg_ready,
  output logic [NUM_LUTS-1:0][2*CFG_SIZE-1:0] luts_config_out,
  output logic config_use_cc,
  output logic config_en,
  output logic cfg_busy,
  output logic cfg_done,
  output logic [CNT_W-1:0] bits_loaded
);

  localparam int LUT_W = 2 * CFG_SIZE;
  localparam logic [CNT_W-1:0] LAST_CNT =
    CNT_W'(FRAME_BITS - 1);

  cfg_state_t state_q;
  cfg_state_t state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic accept;
  logic [FRAME_BITS-1:0] sr;

  // A start in SHIFT aborts, so a bit offered alongside it is dropped.
  assign accept = (state_q == SHIFT) && cfg_valid && !cfg_start;

  always_ff @(posedge config_clk) begin
    if (config_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (cfg_start) begin
          state_d = SHIFT;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        if (cfg_start) begin
          cnt_d = '0;
        end else if (accept) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            state_d = COMMIT;
          end
        end
      end
      COMMIT: state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cfg_ready = 1'b0;
    cfg_busy  = 1'b0;
    config_en = 1'b0;
    cfg_done  = 1'b0;
    unique case (state_q)
      SHIFT: begin
        cfg_ready = 1'b1;
        cfg_busy  = 1'b1;
      end
      COMMIT: begin
        config_en = 1'b1;
        cfg_busy  = 1'b1;
      end
      DONE: cfg_done = 1'b1;
      default: ;
    endcase
  end

  cfg_shift_reg #(
    .WIDTH(FRAME_BITS)
  ) u_sr (
    .clk_i     (config_clk),
    .clr_i     (config_rst),
    .shift_en_i(accept),
    .bit_i     (cfg_bit),
    .data_o    (sr)
  );

  assign bits_loaded   = cnt_q;
  assign config_use_cc = sr[FRAME_BITS-1];

  for (genvar i = 0; i < NUM_LUTS; i++) begin : g_lut
    assign luts_config_out[i] = sr[i*LUT_W +: LUT_W];
  end

endmodule

// File: tb/tb_slice_config_loader.sv
// Randomized bench for slice_config_loader against a frame-level model.
// Outputs are sampled on the falling edge, inputs driven after it.
module tb_slice_config_loader;

  localparam int NL = 4;
  localparam int LW = 34;
  localparam int FB = NL * LW + 1;

  logic config_clk;
  logic config_rst;
  logic cfg_start;
  logic cfg_bit;
  logic cfg_valid;
  logic cfg_ready;
  logic [NL-1:0][LW-1:0] luts;
  logic config_use_cc;
  logic config_en;
  logic cfg_busy;
  logic cfg_done;
  logic [7:0] bits_loaded;

  slice_config_loader dut (
    .config_clk     (config_clk),
    .config_rst     (config_rst),
    .cfg_start      (cfg_start),
    .cfg_bit        (cfg_bit),
    .cfg_valid      (cfg_valid),
    .cfg_ready      (cfg_ready),
    .luts_config_out(luts),
    .config_use_cc  (config_use_cc),
    .config_en      (config_en),
    .cfg_busy       (cfg_busy),
    .cfg_done       (cfg_done),
    .bits_loaded    (bits_loaded)
  );

  initial config_clk = 1'b0;
  always #5 config_clk = ~config_clk;

  int vectors = 0;
  int errs = 0;

  // Model: frame progress as a bit queue plus phase flags.
  bit m_load, m_commit, m_done;
  int m_cnt;
  bit m_q[$];
  logic m_cc;
  logic [LW-1:0] m_lut[NL];

  int ncyc = 0;
  int rdy_cyc = 0;
  int en_cyc = 0;
  int en_pulses = 0;
  logic prev_ready = 1'b0;
  logic snap_cc;
  logic [LW-1:0] snap_lut[NL];

  task automatic chk(
    input string tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    vectors++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void model_step(
    input logic r, input logic st,
    input logic v, input logic b
  );
    if (r) begin
      m_load = 0; m_commit = 0; m_done = 0;
      m_cnt = 0; m_q.delete(); m_cc = 0;
      for (int i = 0; i < NL; i++) m_lut[i] = '0;
    end else if (m_commit) begin
      m_commit = 0;
      m_done = 1;
    end else if (m_load) begin
      if (st) begin
        m_q.delete();
        m_cnt = 0;
      end else if (v) begin
        m_q.push_back(b);
        m_cnt++;
        if (m_cnt == FB) begin
          m_load = 0;
          m_commit = 1;
          // First bit is use_cc, then LUT NL-1 MSB-first down to LUT 0.
          m_cc = m_q[0];
          for (int l = 0; l < NL; l++)
            for (int k = 0; k < LW; k++)
              m_lut[l][k] = m_q[1 + (NL-1-l)*LW + (LW-1-k)];
        end
      end
    end else if (st) begin
      m_load = 1;
      m_cnt = 0;
      m_q.delete();
      m_done = 0;
    end
  endfunction

  task automatic check_all();
    chk("ready", cfg_ready, m_load);
    chk("busy", cfg_busy, m_load | m_commit);
    chk("config_en", config_en, m_commit);
    chk("done", cfg_done, m_done);
    chk("bits_loaded", bits_loaded, m_cnt);
    if (!m_load) begin
      chk("use_cc", config_use_cc, m_cc);
      for (int i = 0; i < NL; i++)
        chk($sformatf("lut%0d", i), luts[i], m_lut[i]);
    end
  endtask

  task automatic cyc(
    input logic r, input logic st,
    input logic v, input logic b
  );
    config_rst = r;
    cfg_start = st;
    cfg_valid = v;
    cfg_bit = b;
    @(posedge config_clk);
    model_step(r, st, v, b);
    @(negedge config_clk);
    ncyc++;
    check_all();
    if (cfg_ready && !prev_ready) rdy_cyc = ncyc;
    prev_ready = cfg_ready;
    if (config_en) begin
      en_pulses++;
      en_cyc = ncyc;
      snap_cc = config_use_cc;
      for (int i = 0; i < NL; i++) snap_lut[i] = luts[i];
    end
  endtask

  function automatic logic [FB-1:0] rand_frame();
    logic [FB-1:0] f;
    for (int i = 0; i < FB; i++) f[i] = 1'($urandom);
    return f;
  endfunction

  // mode 0: solid valid, 1: 3-cycle gap every 10 bits, 2: random valid
  task automatic send_frame(
    input logic [FB-1:0] fv,
    input int mode,
    input logic st_commit
  );
    int idx;
    int sent;
    int gap;
    int guard;
    logic v;
    idx = FB - 1;
    sent = 0;
    gap = 0;
    guard = 0;
    cyc(0, 1, 1, 1'($urandom));
    while (idx >= 0 && guard < 2000) begin
      guard++;
      if (mode == 0) v = 1'b1;
      else if (mode == 1) v = (gap == 0);
      else v = ($urandom_range(0, 3) != 0);
      if (v) begin
        cyc(0, 0, 1, fv[idx]);
        idx--;
        sent++;
        if (mode == 1 && sent % 10 == 0) gap = 3;
      end else begin
        if (gap > 0) gap--;
        cyc(0, 0, 0, 1'($urandom));
      end
    end
    chk("frame_guard", 64'(guard < 2000), 64'(1));
    cyc(0, st_commit, 1, 1'($urandom));
    cyc(0, 0, 0, 0);
  endtask

  task automatic chk_snap(input string tag, input logic [FB-1:0] fv);
    chk({tag, "_cc"}, snap_cc, fv[FB-1]);
    for (int i = 0; i < NL; i++)
      chk($sformatf("%s_lut%0d", tag, i), snap_lut[i], fv[i*LW +: LW]);
  endtask

  logic [FB-1:0] fixed;
  logic [FB-1:0] fv;

  initial begin
    fixed = {1'b1, 34'h2AAAAAAAA, 34'h155555555,
             34'h155555555, 34'h155555555};
    config_rst = 1'b1;
    cfg_start = 1'b0;
    cfg_valid = 1'b0;
    cfg_bit = 1'b0;

    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    repeat (5) cyc(0, 0, 0, 0);

    en_pulses = 0;
    send_frame(fixed, 0, 0);
    chk("en_latency", 64'(en_cyc - rdy_cyc + 1), 64'(FB + 1));
    chk("en_pulses_full", 64'(en_pulses), 64'(1));
    chk_snap("full", fixed);
    repeat (3) cyc(0, 0, 0, 0);

    en_pulses = 0;
    send_frame(fixed, 1, 0);
    chk("en_pulses_gap", 64'(en_pulses), 64'(1));
    chk_snap("gap", fixed);

    en_pulses = 0;
    fv = rand_frame();
    send_frame(fv, 2, 1);
    chk("en_pulses_b2b", 64'(en_pulses), 64'(1));
    chk_snap("b2b", fv);

    cyc(0, 1, 0, 0);
    for (int i = 0; i < 50; i++) cyc(0, 0, 1, 1'($urandom));
    chk("abort_pre", 64'(bits_loaded), 64'(50));
    en_pulses = 0;
    fv = rand_frame();
    send_frame(fv, 2, 0);
    chk("en_pulses_abort", 64'(en_pulses), 64'(1));
    chk_snap("abort", fv);

    en_pulses = 0;
    cyc(0, 1, 0, 0);
    for (int i = 0; i < 80; i++) cyc(0, 0, 1, 1'($urandom));
    cyc(1, 0, 1, 1);
    repeat (4) cyc(0, 0, 0, 0);
    chk("en_pulses_rst", 64'(en_pulses), 64'(0));
    fv = rand_frame();
    send_frame(fv, 0, 0);
    chk_snap("after_rst", fv);

    fv = rand_frame();
    cyc(0, 1, 0, 0);
    for (int i = FB - 1; i >= 0; i--) cyc(0, 0, 1, fv[i]);
    cyc(1, 0, 0, 0);
    repeat (3) cyc(0, 0, 0, 0);
    chk("done_after_commit_rst", cfg_done, 1'b0);
    chk_snap("commit_rst", fv);

    for (int n = 0; n < 3; n++) begin
      en_pulses = 0;
      fv = rand_frame();
      send_frame(fv, 2, 1'($urandom));
      chk("en_pulses_rand", 64'(en_pulses), 64'(1));
      chk_snap("rand", fv);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errs);
    $finish;
  end

endmodule
